// File: rtl/emif_cfg_capture.sv
// emif_cfg_capture
// Captures one EMIF write per read_en strobe, after the strobe has stayed high
// long enough for address and data to settle. Valid writes go into a small
// register bank. The block provides readback, a mode field, per-register
// update pulses and sticky error flags.
// read_en is a write strobe despite its name; it is already synchronous to clk.
module emif_cfg_capture #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 13,
  parameter int NUM_REGS   = 8,
  parameter int SAMPLE_DLY = 5,
  parameter int MODE_IDX   = 3,
  parameter int MODE_W     = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        read_en,
  input  logic [ADDR_W-1:0]           emif_addr,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  input  logic                        err_clr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [MODE_W-1:0]           mode_out,
  output logic                        cap_done,
  output logic [DATA_W-1:0]           cap_data,
  output logic [ADDR_W-1:0]           cap_addr,
  output logic [NUM_REGS-1:0]         upd_vec,
  output logic                        addr_err,
  output logic                        short_err
);

  // Compare width: wide enough for both the full address and NUM_REGS (<=256),
  // so range checks never truncate either operand.
  localparam int CW = (ADDR_W > 9) ? ADDR_W : 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  sample;     // this edge is the sample edge
  logic                  short_evt;  // strobe dropped before the sample edge
  logic                  addr_ok;
  logic [NUM_REGS-1:0]   hit;
  logic [DATA_W-1:0]     bank [NUM_REGS];

  assign addr_ok = CW'(emif_addr) < CW'(NUM_REGS);

  // State register and settle counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: count strobe-high cycles and fire one sample per strobe.
  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sample    = 1'b0;
    short_evt = 1'b0;
    unique case (state)
      IDLE: begin
        if (read_en) begin
          state_nxt = WAIT;
          cnt_nxt   = 4'd1;
        end
      end
      WAIT: begin
        if (!read_en) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          short_evt = 1'b1;
        end else if (cnt < 4'(SAMPLE_DLY)) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          sample    = 1'b1;
          state_nxt = HOLD;
          cnt_nxt   = 4'd0;
        end
      end
      HOLD: begin
        if (!read_en) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // One-hot write select: full-width address match against each bank index.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = sample && (CW'(emif_addr) == CW'(i));
    end
  end

  // Register bank, written only at the sample edge of an in-range address.
  // NOTE: the bank is small and must read as zero after reset, so it is
  // built from reset flops rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hit[i]) bank[i] <= data_in;
      end
    end
  end

  // Capture outputs: held sample values plus one-cycle done/update pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_done <= 1'b0;
      cap_data <= '0;
      cap_addr <= '0;
      upd_vec  <= '0;
    end else begin
      cap_done <= sample;
      upd_vec  <= hit;
      if (sample) begin
        cap_data <= data_in;
        cap_addr <= emif_addr;
      end
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err  <= 1'b0;
      short_err <= 1'b0;
    end else begin
      addr_err  <= (sample && !addr_ok) || (addr_err && !err_clr);
      short_err <= short_evt || (short_err && !err_clr);
    end
  end

  // Registered readback and mode field, both taken from the bank's current contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      mode_out <= '0;
    end else begin
      if (CW'(rd_idx) < CW'(NUM_REGS)) rd_data <= bank[rd_idx];
      else                             rd_data <= '0;
      mode_out <= bank[MODE_IDX][MODE_W-1:0];
    end
  end

endmodule

// File: tb/tb_emif_cfg_capture.sv
// tb_emif_cfg_capture
// Randomised and directed strobes against a run-length reference model. The
// model pushes each expected capture into a queue. A negedge monitor pops the
// queue whenever cap_done is seen and compares the outputs against the model state.
module tb_emif_cfg_capture;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 13;
  localparam int NUM_REGS   = 8;
  localparam int SAMPLE_DLY = 5;
  localparam int MODE_IDX   = 3;
  localparam int MODE_W     = 5;

  logic                clk;
  logic                rst_n;
  logic                read_en;
  logic [ADDR_W-1:0]   emif_addr;
  logic [DATA_W-1:0]   data_in;
  logic [2:0]          rd_idx;
  logic                err_clr;
  logic [DATA_W-1:0]   rd_data;
  logic [MODE_W-1:0]   mode_out;
  logic                cap_done;
  logic [DATA_W-1:0]   cap_data;
  logic [ADDR_W-1:0]   cap_addr;
  logic [NUM_REGS-1:0] upd_vec;
  logic                addr_err;
  logic                short_err;

  emif_cfg_capture #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
    .SAMPLE_DLY(SAMPLE_DLY), .MODE_IDX(MODE_IDX), .MODE_W(MODE_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read_en(read_en), .emif_addr(emif_addr),
    .data_in(data_in), .rd_idx(rd_idx), .err_clr(err_clr), .rd_data(rd_data),
    .mode_out(mode_out), .cap_done(cap_done), .cap_data(cap_data),
    .cap_addr(cap_addr), .upd_vec(upd_vec), .addr_err(addr_err),
    .short_err(short_err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [NUM_REGS-1:0] upd;
  } cap_t;

  cap_t exp_q[$];

  // Reference model state: the expected DUT outputs after the next clock edge.
  logic [DATA_W-1:0] m_bank [NUM_REGS];
  int                m_run;  // consecutive strobe-high edges seen
  logic [DATA_W-1:0] m_rd;
  logic [MODE_W-1:0] m_mode;
  logic [DATA_W-1:0] m_cap_data;
  logic [ADDR_W-1:0] m_cap_addr;
  logic              m_addr_err;
  logic              m_short_err;

  int checks = 0;
  int errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_bank[i] = '0;
    m_run       = 0;
    m_rd        = '0;
    m_mode      = '0;
    m_cap_data  = '0;
    m_cap_addr  = '0;
    m_addr_err  = 1'b0;
    m_short_err = 1'b0;
    exp_q.delete();
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic short_set;
    logic addr_set;
    cap_t e;
    short_set = 1'b0;
    addr_set  = 1'b0;
    m_rd   = (int'(rd_idx) < NUM_REGS) ? m_bank[rd_idx] : '0;
    m_mode = m_bank[MODE_IDX][MODE_W-1:0];
    if (read_en) begin
      if (m_run < SAMPLE_DLY + 2) m_run++;
      if (m_run == SAMPLE_DLY + 1) begin
        e.addr = emif_addr;
        e.data = data_in;
        e.upd  = '0;
        m_cap_addr = emif_addr;
        m_cap_data = data_in;
        if (int'(emif_addr) < NUM_REGS) begin
          m_bank[int'(emif_addr)] = data_in;
          e.upd = NUM_REGS'(1) << emif_addr;
        end else begin
          addr_set = 1'b1;
        end
        exp_q.push_back(e);
      end
    end else begin
      if (m_run >= 1 && m_run <= SAMPLE_DLY) short_set = 1'b1;
      m_run = 0;
    end
    m_addr_err  = addr_set  | (m_addr_err  & ~err_clr);
    m_short_err = short_set | (m_short_err & ~err_clr);
  endtask

  task automatic apply(input logic re, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [2:0] ri, input logic ec);
    read_en   = re;
    emif_addr = a;
    data_in   = d;
    rd_idx    = ri;
    err_clr   = ec;
    model_step();
  endtask

  // Drive inputs for the next rising edge, away from the monitor's negedge sample.
  task automatic tick(input logic re, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [2:0] ri, input logic ec);
    @(negedge clk);
    #2;
    apply(re, a, d, ri, ec);
  endtask

  task automatic strobe(input int len, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [2:0] ri);
    for (int i = 0; i < len; i++) tick(1'b1, a, d, ri, 1'b0);
    tick(1'b0, a, d, ri, 1'b0);
  endtask

  // Monitor: scoreboard pop on cap_done, plus per-cycle state comparison.
  initial begin
    cap_t e;
    forever begin
      @(negedge clk);
      if (cap_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_cap_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cap_addr_at_done", 32'(cap_addr), 32'(e.addr));
          check("cap_data_at_done", 32'(cap_data), 32'(e.data));
          check("upd_vec_at_done",  32'(upd_vec),  32'(e.upd));
        end
      end else begin
        check("upd_vec_idle", 32'(upd_vec), 32'd0);
        if (exp_q.size() != 0) begin
          check("missing_cap_done", 32'd0, 32'd1);
          void'(exp_q.pop_front());
        end
      end
      check("cap_data_held", 32'(cap_data),  32'(m_cap_data));
      check("cap_addr_held", 32'(cap_addr),  32'(m_cap_addr));
      check("rd_data",       32'(rd_data),   32'(m_rd));
      check("mode_out",      32'(mode_out),  32'(m_mode));
      check("addr_err",      32'(addr_err),  32'(m_addr_err));
      check("short_err",     32'(short_err), 32'(m_short_err));
    end
  end

  initial begin
    logic [ADDR_W-1:0] ra;
    int                len;
    rst_n     = 1'b0;
    read_en   = 1'b0;
    emif_addr = '0;
    data_in   = '0;
    rd_idx    = '0;
    err_clr   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    apply(1'b0, '0, '0, 3'd0, 1'b0);
    tick(1'b0, '0, '0, 3'd0, 1'b0);

    // Nominal write to the mode register.
    strobe(10, 13'd3, 16'h0015, 3'd3);
    check("dir_mode_out",  32'(mode_out), 32'h15);
    check("dir_cap_addr",  32'(cap_addr), 32'd3);
    check("dir_rd_mode",   32'(rd_data),  32'h0015);

    // Short strobe: no write, sticky flag, then clear.
    strobe(4, 13'd2, 16'hABCD, 3'd2);
    tick(1'b0, '0, '0, 3'd2, 1'b0);
    check("dir_short_set",   32'(short_err), 32'd1);
    check("dir_short_nowr",  32'(rd_data),   32'd0);
    tick(1'b0, '0, '0, 3'd2, 1'b1);
    tick(1'b0, '0, '0, 3'd2, 1'b0);
    check("dir_short_clr",   32'(short_err), 32'd0);

    // Out-of-range address: capture but no bank write.
    strobe(8, 13'h0008, 16'hBEEF, 3'd3);
    tick(1'b0, '0, '0, 3'd3, 1'b0);
    check("dir_addr_err",   32'(addr_err), 32'd1);
    check("dir_oor_addr",   32'(cap_addr), 32'd8);
    check("dir_oor_data",   32'(cap_data), 32'hBEEF);
    check("dir_oor_nowr",   32'(rd_data),  32'h0015);
    tick(1'b0, '0, '0, 3'd3, 1'b1);
    tick(1'b0, '0, '0, 3'd3, 1'b0);
    check("dir_addr_clr",   32'(addr_err), 32'd0);

    // Back-to-back strobes with a single idle cycle between them.
    strobe(7, 13'd0, 16'h1111, 3'd0);
    strobe(7, 13'd7, 16'h7777, 3'd0);
    tick(1'b0, '0, '0, 3'd0, 1'b0);
    tick(1'b0, '0, '0, 3'd7, 1'b0);
    check("dir_rd_reg0", 32'(rd_data), 32'h1111);
    tick(1'b0, '0, '0, 3'd7, 1'b0);
    check("dir_rd_reg7", 32'(rd_data), 32'h7777);

    // Reset in the middle of the settle count.
    repeat (3) tick(1'b1, 13'd5, 16'h5555, 3'd5, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mode_out",  32'(mode_out),  32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    check("rst_cap_done",  32'(cap_done),  32'd0);
    check("rst_cap_addr",  32'(cap_addr),  32'd0);
    check("rst_cap_data",  32'(cap_data),  32'd0);
    check("rst_upd_vec",   32'(upd_vec),   32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    apply(1'b1, 13'd5, 16'h5555, 3'd5, 1'b0);
    tick(1'b1, 13'd5, 16'h5555, 3'd5, 1'b0);
    tick(1'b0, 13'd5, 16'h5555, 3'd5, 1'b1);
    tick(1'b0, '0, '0, 3'd5, 1'b0);
    check("dir_short_wins_clr", 32'(short_err), 32'd1);
    check("dir_rst_nowr",       32'(rd_data),   32'd0);

    // Random strobes, addresses, data, readback indices and clears.
    for (int n = 0; n < 60; n++) begin
      len = $urandom_range(1, 12);
      ra  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(8, 8191))
                                        : ADDR_W'($urandom_range(0, 7));
      for (int i = 0; i < len; i++) begin
        tick(1'b1, ra, DATA_W'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0));
      end
      for (int i = 0, g = $urandom_range(1, 3); i < g; i++) begin
        tick(1'b0, ADDR_W'($urandom), DATA_W'($urandom), 3'($urandom),
             ($urandom_range(0, 5) == 0));
      end
    end

    repeat (3) tick(1'b0, '0, '0, 3'd0, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/emif_cfg_capture.md
EMIF_CFG_CAPTURE -- requirements
Module: emif_cfg_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning EMIF data width.
REQ-002 SHALL have parameter ADDR_W, default 13, meaning EMIF address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, meaning register bank depth (2..256).
REQ-004 SHALL have parameter SAMPLE_DLY, default 5, meaning strobe-settle cycles before sampling (1..15).
REQ-005 SHALL have parameter MODE_IDX, default 3, meaning bank index driving mode_out (< NUM_REGS).
REQ-006 SHALL have parameter MODE_W, default 5, meaning mode_out width (<= DATA_W).
REQ-007 SHALL have port clk, input, 1, system clock, 200 MHz.
REQ-008 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have port read_en, input, 1, EMIF write strobe, already synchronous to clk.
REQ-010 SHALL have port emif_addr, input, ADDR_W, EMIF address.
REQ-011 SHALL have port data_in, input, DATA_W, EMIF data.
REQ-012 SHALL have port rd_idx, input, IW=$clog2(NUM_REGS), readback index.
REQ-013 SHALL have port err_clr, input, 1, clears addr_err and short_err.
REQ-014 SHALL have port rd_data, output, DATA_W, registered readback of bank[rd_idx].
REQ-015 SHALL have port mode_out, output, MODE_W, bank[MODE_IDX][MODE_W-1:0], registered.
REQ-016 SHALL have port cap_done, output, 1, one-cycle capture pulse.
REQ-017 SHALL have port cap_data, output, DATA_W, last sampled data, held.
REQ-018 SHALL have port cap_addr, output, ADDR_W, last sampled address, held.
REQ-019 SHALL have port upd_vec, output, NUM_REGS, one-hot one-cycle per-register update pulse.
REQ-020 SHALL have port addr_err, output, 1, sticky out-of-range address flag.
REQ-021 SHALL have port short_err, output, 1, sticky strobe-too-short flag.

Function
REQ-022 SHALL implement FSM IDLE, WAIT, HOLD with a 4-bit settle counter cnt.
REQ-023 IDLE: read_en=1 SHALL go to WAIT with cnt=1; read_en=0 stays IDLE.
REQ-024 WAIT: read_en=1 and cnt<SAMPLE_DLY SHALL increment cnt.
REQ-025 WAIT: read_en=1 and cnt==SAMPLE_DLY SHALL sample data_in/emif_addr and go to HOLD; sample edge = (SAMPLE_DLY+1)th consecutive clock with read_en=1.
REQ-026 WAIT: read_en=0 SHALL go to IDLE, no capture, set short_err.
REQ-027 HOLD: SHALL stay until read_en=0, then go to IDLE; exactly one capture per strobe regardless of strobe length.
REQ-028 At sample edge SHALL load cap_data/cap_addr and assert cap_done for exactly the following cycle.
REQ-029 If emif_addr < NUM_REGS (full ADDR_W compare, no truncation), SHALL write bank[emif_addr]<=data_in at the sample edge and pulse upd_vec[emif_addr] coincident with cap_done.
REQ-030 If emif_addr >= NUM_REGS, SHALL leave bank unchanged, upd_vec=0, set addr_err; cap_done still pulses.
REQ-031 rd_data SHALL equal bank[rd_idx] one cycle after rd_idx is presented, reflecting writes of the previous edge; rd_idx >= NUM_REGS SHALL return 0.
REQ-032 mode_out SHALL update one cycle after bank[MODE_IDX] changes.
REQ-033 err_clr SHALL clear both sticky flags next cycle; a new error in the same cycle SHALL win (flag remains 1).
REQ-034 Back-to-back strobes SHALL require >=1 cycle read_en=0 between them; each yields one capture.

Reset
REQ-035 rst_n=0 SHALL asynchronously force FSM=IDLE, cnt=0, bank all 0, rd_data=0, mode_out=0, cap_done=0, cap_data=0, cap_addr=0, upd_vec=0, addr_err=0, short_err=0.
REQ-036 Reset mid-strobe SHALL abort with no capture; after release with read_en still 1, a new count SHALL start from IDLE on the first clock.

Verification
REQ-037 SAMPLE_DLY=5, read_en high 10 cycles, addr=3, data=16'h0015 -> cap_done on cycle 7 after rise, upd_vec=8'b0000_1000, mode_out=5'h15 one cycle later.
REQ-038 read_en high 4 cycles, addr=2 -> no cap_done, bank[2] unchanged, short_err=1; err_clr -> short_err=0.
REQ-039 addr=13'h0008 (NUM_REGS=8), data=16'hBEEF -> cap_done=1, cap_addr=8, upd_vec=0, addr_err=1, bank unchanged.
REQ-040 Two strobes separated by one idle cycle to addr 0 (16'h1111) then addr 7 (16'h7777) -> two cap_done pulses; rd_idx=0/7 reads 16'h1111/16'h7777.
REQ-041 rst_n low during WAIT at cnt=3 -> all outputs 0, no capture; err_clr coincident with new short strobe -> short_err stays 1.
